// File: rtl/pulse_pattern_monitor.sv
// Captures WIDTH serial samples after a start request and reports the rebuilt word,
// its longest high/low runs, its edge count, and whether it equals an expected pattern.
module pulse_pattern_monitor #(
    parameter int WIDTH = 16,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             serial_in,
    input  logic [WIDTH-1:0] expected,
    output logic             busy,
    output logic             valid,
    output logic             match,
    output logic [WIDTH-1:0] captured,
    output logic [CNT_W-1:0] high_run,
    output logic [CNT_W-1:0] low_run,
    output logic [CNT_W-1:0] edge_count
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CAPTURE = 2'd1,
        S_DONE    = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LP_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] LP_FULL = CNT_W'(WIDTH);

    state_t r_state;
    state_t w_state_nxt;

    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_shift;
    logic             r_prev;
    logic [CNT_W-1:0] r_run;
    logic [CNT_W-1:0] r_max_hi;
    logic [CNT_W-1:0] r_max_lo;
    logic [CNT_W-1:0] r_edges;

    logic             r_valid;
    logic             r_match;
    logic [WIDTH-1:0] r_captured;
    logic [CNT_W-1:0] r_high_run;
    logic [CNT_W-1:0] r_low_run;
    logic [CNT_W-1:0] r_edge_count;

    logic             w_accept;
    logic             w_sample;
    logic             w_first;
    logic             w_same;
    logic             w_last;
    logic [CNT_W-1:0] w_run_nxt;
    logic [CNT_W-1:0] w_edges_nxt;
    logic [CNT_W-1:0] w_max_hi_nxt;
    logic [CNT_W-1:0] w_max_lo_nxt;
    logic [WIDTH-1:0] w_shift_nxt;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // DONE behaves like IDLE for start, which gives back-to-back windows of WIDTH+1 cycles
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_sample    = 1'b0;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    w_state_nxt = S_CAPTURE;
                    w_accept    = 1'b1;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_CAPTURE: begin
                w_sample = 1'b1;
                if (w_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Per-sample tracker update; also feeds the result registers on the final sample
    always_comb begin
        w_first      = (r_cnt == '0);
        w_same       = (serial_in == r_prev);
        w_last       = (r_cnt == LP_LAST);
        w_run_nxt    = LP_ONE;
        if (!w_first && w_same) begin
            w_run_nxt = (r_run == LP_FULL) ? LP_FULL : r_run + LP_ONE;
        end
        w_edges_nxt  = r_edges + ((!w_first && !w_same) ? LP_ONE : '0);
        w_max_hi_nxt = r_max_hi;
        w_max_lo_nxt = r_max_lo;
        if (serial_in) begin
            if (w_run_nxt > r_max_hi) w_max_hi_nxt = w_run_nxt;
        end else begin
            if (w_run_nxt > r_max_lo) w_max_lo_nxt = w_run_nxt;
        end
        w_shift_nxt  = {r_shift[WIDTH-2:0], serial_in};
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_cnt        <= '0;
            r_shift      <= '0;
            r_prev       <= 1'b0;
            r_run        <= '0;
            r_max_hi     <= '0;
            r_max_lo     <= '0;
            r_edges      <= '0;
            r_valid      <= 1'b0;
            r_match      <= 1'b0;
            r_captured   <= '0;
            r_high_run   <= '0;
            r_low_run    <= '0;
            r_edge_count <= '0;
        end else begin
            r_valid <= w_sample && w_last;
            if (w_accept) begin
                r_cnt    <= '0;
                r_shift  <= '0;
                r_prev   <= 1'b0;
                r_run    <= '0;
                r_max_hi <= '0;
                r_max_lo <= '0;
                r_edges  <= '0;
            end else if (w_sample) begin
                r_cnt    <= r_cnt + LP_ONE;
                r_shift  <= w_shift_nxt;
                r_prev   <= serial_in;
                r_run    <= w_run_nxt;
                r_max_hi <= w_max_hi_nxt;
                r_max_lo <= w_max_lo_nxt;
                r_edges  <= w_edges_nxt;
                if (w_last) begin
                    r_captured   <= w_shift_nxt;
                    r_match      <= (w_shift_nxt == expected);
                    r_high_run   <= w_max_hi_nxt;
                    r_low_run    <= w_max_lo_nxt;
                    r_edge_count <= w_edges_nxt;
                end
            end
        end
    end

    assign busy       = (r_state == S_CAPTURE);
    assign valid      = r_valid;
    assign match      = r_match;
    assign captured   = r_captured;
    assign high_run   = r_high_run;
    assign low_run    = r_low_run;
    assign edge_count = r_edge_count;

endmodule

// File: tb/tb_pulse_pattern_monitor.sv
// Randomized and directed windows against a word-level reference model of pulse_pattern_monitor.
module tb_pulse_pattern_monitor;

    localparam int W  = 16;
    localparam int CW = $clog2(W) + 1;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          serial_in = 1'b0;
    logic [W-1:0]  expected = '0;
    logic          busy;
    logic          valid;
    logic          match;
    logic [W-1:0]  captured;
    logic [CW-1:0] high_run;
    logic [CW-1:0] low_run;
    logic [CW-1:0] edge_count;

    int n_vec = 0;
    int n_err = 0;

    pulse_pattern_monitor #(.WIDTH(W), .CNT_W(CW)) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .serial_in  (serial_in),
        .expected   (expected),
        .busy       (busy),
        .valid      (valid),
        .match      (match),
        .captured   (captured),
        .high_run   (high_run),
        .low_run    (low_run),
        .edge_count (edge_count)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Longest run of ones: number of x &= x>>1 steps until the word empties
    function automatic int longest_ones(input logic [W-1:0] v);
        logic [W-1:0] x;
        int n;
        x = v;
        n = 0;
        while (x != '0) begin
            x = x & (x >> 1);
            n++;
        end
        return n;
    endfunction

    function automatic int count_edges(input logic [W-1:0] v);
        logic [W-1:0] mask;
        mask = {1'b0, {(W-1){1'b1}}};
        return $countones((v ^ (v >> 1)) & mask);
    endfunction

    task automatic check_results(input logic [W-1:0] pat, input logic [W-1:0] exp);
        chk("captured",   32'(captured),   32'(pat));
        chk("high_run",   32'(high_run),   32'(longest_ones(pat)));
        chk("low_run",    32'(low_run),    32'(longest_ones(~pat)));
        chk("edge_count", 32'(edge_count), 32'(count_edges(pat)));
        chk("match",      32'(match),      32'(pat == exp));
    endtask

    // Entered at a negedge; start is accepted at the following posedge (edge k).
    // Returns at the negedge after edge k+W, i.e. inside the DONE cycle.
    task automatic run_window(input logic [W-1:0] pat, input logic [W-1:0] exp,
                              input bit keep_start, input int poke);
        start    = 1'b1;
        expected = exp;
        for (int i = 0; i < W; i++) begin
            @(negedge clock);
            chk("busy_capture",  32'(busy),  32'd1);
            chk("valid_capture", 32'(valid), 32'd0);
            serial_in = pat[W-1-i];
            start     = keep_start || (i == poke);
        end
        @(negedge clock);
        chk("busy_done",  32'(busy),  32'd0);
        chk("valid_done", 32'(valid), 32'd1);
        check_results(pat, exp);
        start = keep_start;
    endtask

    task automatic finish_window(input logic [W-1:0] pat, input logic [W-1:0] exp);
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            chk("valid_after", 32'(valid), 32'd0);
            chk("busy_after",  32'(busy),  32'd0);
        end
        check_results(pat, exp);
    endtask

    initial begin
        logic [W-1:0] pat;
        logic [W-1:0] exp;
        logic [W-1:0] prev_pat;
        logic [W-1:0] prev_exp;
        bit           b2b;

        #2;
        chk("rst_busy",     32'(busy),       32'd0);
        chk("rst_valid",    32'(valid),      32'd0);
        chk("rst_match",    32'(match),      32'd0);
        chk("rst_captured", 32'(captured),   32'd0);
        chk("rst_high",     32'(high_run),   32'd0);
        chk("rst_low",      32'(low_run),    32'd0);
        chk("rst_edges",    32'(edge_count), 32'd0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);

        // Directed patterns, isolated windows
        run_window(16'hAAAA, 16'hAAAA, 1'b0, -1); finish_window(16'hAAAA, 16'hAAAA);
        run_window(16'hCCCC, 16'hCCCC, 1'b0, -1); finish_window(16'hCCCC, 16'hCCCC);
        run_window(16'hF0F0, 16'hF0F0, 1'b0, -1); finish_window(16'hF0F0, 16'hF0F0);
        run_window(16'hE000, 16'h0001, 1'b0, -1); finish_window(16'hE000, 16'h0001);
        run_window(16'hFFFF, 16'hFFFF, 1'b0, -1); finish_window(16'hFFFF, 16'hFFFF);
        run_window(16'h0000, 16'h1234, 1'b0, -1); finish_window(16'h0000, 16'h1234);

        // start held high: windows every W+1 cycles
        run_window(16'h8001, 16'h8001, 1'b1, -1);
        run_window(16'h7FFE, 16'h0000, 1'b0, -1);
        finish_window(16'h7FFE, 16'h0000);

        // start pulsed mid-capture is ignored
        run_window(16'h3C5A, 16'h3C5A, 1'b0, 5);
        finish_window(16'h3C5A, 16'h3C5A);

        // Reset after 7 samples aborts the window
        start    = 1'b1;
        expected = 16'hFFFF;
        for (int i = 0; i < 7; i++) begin
            @(negedge clock);
            serial_in = 1'b1;
            start     = 1'b0;
        end
        @(negedge clock);
        reset = 1'b1;
        #1;
        chk("abort_busy",     32'(busy),       32'd0);
        chk("abort_valid",    32'(valid),      32'd0);
        chk("abort_match",    32'(match),      32'd0);
        chk("abort_captured", 32'(captured),   32'd0);
        chk("abort_high",     32'(high_run),   32'd0);
        chk("abort_low",      32'(low_run),    32'd0);
        chk("abort_edges",    32'(edge_count), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < W; i++) begin
            @(negedge clock);
            chk("abort_no_valid", 32'(valid), 32'd0);
            chk("abort_idle",     32'(busy),  32'd0);
        end
        run_window(16'h0F31, 16'h0F31, 1'b0, -1);
        finish_window(16'h0F31, 16'h0F31);

        // Randomized windows, mixing back-to-back and idle gaps
        prev_pat = '0;
        prev_exp = '0;
        b2b      = 1'b0;
        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 5))
                0:       pat = W'(1) << $urandom_range(0, W-1);
                1:       pat = ~(W'(1) << $urandom_range(0, W-1));
                default: pat = W'($urandom);
            endcase
            exp = ($urandom_range(0, 1) == 1) ? pat : pat ^ (W'(1) << $urandom_range(0, W-1));
            b2b = ($urandom_range(0, 1) == 1) && (n != 39);
            run_window(pat, exp, b2b, ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, W-2)) : -1);
            if (!b2b) finish_window(pat, exp);
            prev_pat = pat;
            prev_exp = exp;
        end
        check_results(prev_pat, prev_exp);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
